// File: rtl/mp_pkg.sv
// Shared definitions for the carry-save accumulator: command encoding,
// controller states and the segment-count helper.
package mp_pkg;

    localparam logic [1:0] OP_ADD       = 2'd0;
    localparam logic [1:0] OP_ADD_SHIFT = 2'd1;
    localparam logic [1:0] OP_SHIFT     = 2'd2;
    localparam logic [1:0] OP_RESOLVE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_SUB     = 2'd2,
        ST_DONE    = 2'd3
    } mp_state_e;

    function automatic int mp_nseg(input int width, input int seg_w);
        return (width + seg_w - 1) / seg_w;
    endfunction

endpackage

// File: rtl/mp_csa_cell.sv
// One bit of the 3:2 compressor: sum and majority of three inputs.
module mp_csa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic maj
);

    assign sum = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/mp_csa_accum.sv
// Carry-save accumulator with segmented resolve adder. Define
// MP_CSA_ACCUM_REDUCE_EN to add modulo-M reduction by repeated subtraction.
module mp_csa_accum
    import mp_pkg::*;
#(
    parameter int WIDTH = 514,
    parameter int SEG_W = 103
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_clear,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] modulus,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             lsb0,
    output logic             lsb1,
    output logic             busy
);

    localparam int NSEG   = mp_nseg(WIDTH, SEG_W);
    localparam int TOP_W  = WIDTH - (NSEG - 1) * SEG_W;
    localparam int SEG_IW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEG_IW-1:0] LAST_SEG = SEG_IW'(NSEG - 1);
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam logic [WIDTH-1:0] LOW_MASK = ONES >> (WIDTH - SEG_W);
    localparam logic [WIDTH-1:0] TOP_MASK = ONES >> (WIDTH - TOP_W);

    mp_state_e         state_q, state_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic [SEG_IW-1:0] seg_q, seg_d;
    logic              res_valid_q, res_valid_d;

`ifdef MP_CSA_ACCUM_REDUCE_EN
    logic [WIDTH-1:0]  d_q, d_d;
    logic [15:0]       pass_q, pass_d;
`else
    logic              unused_modulus;
    assign unused_modulus = ^modulus;
`endif

    logic [WIDTH-1:0]  s_in, c_in;
    logic [WIDTH-1:0]  csa_sum, csa_maj;
    logic [WIDTH-1:0]  add_s, add_c;

    // cmd_clear makes the compressor see an empty accumulator.
    assign s_in = cmd_clear ? '0 : s_q;
    assign c_in = cmd_clear ? '0 : c_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mp_csa_cell u_cell (
            .a   (s_in[i]),
            .b   (c_in[i]),
            .c   (operand[i]),
            .sum (csa_sum[i]),
            .maj (csa_maj[i])
        );
    end

    assign add_s = csa_sum;
    assign add_c = csa_maj << 1;

    int               shamt;
    logic [WIDTH-1:0] seg_mask;
    logic [WIDTH-1:0] place_mask;
    logic [SEG_W-1:0] op_a, op_b;
    logic             cin;
    logic [SEG_W:0]   seg_sum;
    logic             seg_cout;
    logic [WIDTH-1:0] seg_place;

    // One segment of the shared ripple adder; the top segment is narrower,
    // so its carry-out is taken from bit TOP_W instead of SEG_W.
    always_comb begin
        shamt      = int'(seg_q) * SEG_W;
        seg_mask   = (seg_q == LAST_SEG) ? TOP_MASK : LOW_MASK;
        place_mask = seg_mask << shamt;
        op_a       = SEG_W'((s_q >> shamt) & seg_mask);
        op_b       = SEG_W'((c_q >> shamt) & seg_mask);
        cin        = carry_q;
`ifdef MP_CSA_ACCUM_REDUCE_EN
        if (state_q == ST_SUB) begin
            op_a = SEG_W'((r_q >> shamt) & seg_mask);
            op_b = SEG_W'(~(modulus >> shamt) & seg_mask);
            cin  = (seg_q == '0) ? 1'b1 : carry_q;
        end
`endif
        seg_sum   = {1'b0, op_a} + {1'b0, op_b} + {{SEG_W{1'b0}}, cin};
        seg_cout  = (seg_q == LAST_SEG) ? seg_sum[TOP_W] : seg_sum[SEG_W];
        seg_place = (WIDTH'(seg_sum[SEG_W-1:0]) << shamt) & place_mask;
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        r_d         = r_q;
        res_d       = res_q;
        carry_d     = carry_q;
        seg_d       = seg_q;
        res_valid_d = 1'b0;
`ifdef MP_CSA_ACCUM_REDUCE_EN
        d_d         = d_q;
        pass_d      = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_ADD: begin
                            s_d = add_s;
                            c_d = add_c;
                        end
                        OP_ADD_SHIFT: begin
                            s_d = add_s >> 1;
                            c_d = add_c >> 1;
                        end
                        OP_SHIFT: begin
                            s_d = s_q >> 1;
                            c_d = c_q >> 1;
                        end
                        default: begin
                            state_d = ST_RESOLVE;
                            seg_d   = '0;
                            carry_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_RESOLVE: begin
                r_d     = (r_q & ~place_mask) | seg_place;
                carry_d = seg_cout;
                seg_d   = seg_q + SEG_IW'(1);
                if (seg_q == LAST_SEG) begin
                    seg_d   = '0;
                    carry_d = 1'b0;
`ifdef MP_CSA_ACCUM_REDUCE_EN
                    pass_d  = '0;
                    state_d = (modulus != '0) ? ST_SUB : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef MP_CSA_ACCUM_REDUCE_EN
            ST_SUB: begin
                d_d     = (d_q & ~place_mask) | seg_place;
                carry_d = seg_cout;
                seg_d   = seg_q + SEG_IW'(1);
                if (seg_q == LAST_SEG) begin
                    seg_d   = '0;
                    carry_d = 1'b0;
                    pass_d  = pass_q + 16'd1;
                    // No borrow out of the top segment means R >= M: keep going.
                    if (seg_cout) begin
                        r_d = d_d;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: begin
                res_d       = r_q;
                res_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            seg_q       <= '0;
            res_valid_q <= 1'b0;
`ifdef MP_CSA_ACCUM_REDUCE_EN
            d_q         <= '0;
            pass_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            r_q         <= r_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            seg_q       <= seg_d;
            res_valid_q <= res_valid_d;
`ifdef MP_CSA_ACCUM_REDUCE_EN
            d_q         <= d_d;
            pass_q      <= pass_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_q;
    assign lsb0      = s_q[0] ^ c_q[0];
    assign lsb1      = s_q[1] ^ c_q[1] ^ (s_q[0] & c_q[0]);

endmodule
